// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-programmable raster timing generator.
// The fetch stage exposes the raw counters so the screen RAM / char ROM can be addressed.
// The display stage re-times sync, blanking and position to line up with returned pixels.
// Timing fields are double-buffered and swap atomically at the end of a frame.
module vga_timing_gen #(
   parameter int CW    = 11,
   parameter int LEAD  = 2,
   parameter int H_ACT = 640,
   parameter int H_FP  = 16,
   parameter int H_SW  = 96,
   parameter int H_BP  = 48,
   parameter int V_ACT = 480,
   parameter int V_FP  = 10,
   parameter int V_SW  = 2,
   parameter int V_BP  = 33,
   parameter bit H_POL = 1'b0,
   parameter bit V_POL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_ce,
   input  logic          cfg_wr,
   input  logic [3:0]    cfg_sel,
   input  logic [CW-1:0] cfg_data,
   input  logic          cfg_apply,
   output logic          cfg_pending,
   output logic          cfg_err,
   output logic [CW-1:0] fetch_x,
   output logic [CW-1:0] fetch_y,
   output logic          fetch_valid,
   output logic          h_sync_o,
   output logic          v_sync_o,
   output logic          de_o,
   output logic [CW-1:0] posx_o,
   output logic [CW-1:0] posy_o,
   output logic          frame_start,
   output logic          line_irq
);

   localparam int TW = CW + 2;

   typedef logic [CW-1:0] field_t;

   typedef struct packed {
      logic   hs;
      logic   vs;
      logic   de;
      field_t x;
      field_t y;
   } stage_t;

   localparam stage_t IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0, x: '0, y: '0};

   // Field order matches cfg_sel 0..7.
   function automatic field_t field_default(input logic [2:0] idx);
      case (idx)
         3'd0:    return field_t'(H_ACT);
         3'd1:    return field_t'(H_FP);
         3'd2:    return field_t'(H_SW);
         3'd3:    return field_t'(H_BP);
         3'd4:    return field_t'(V_ACT);
         3'd5:    return field_t'(V_FP);
         3'd6:    return field_t'(V_SW);
         default: return field_t'(V_BP);
      endcase
   endfunction

   field_t        live_f [8];
   field_t        shad_f [8];
   logic [1:0]    live_pol;   // {v_pol, h_pol}
   logic [1:0]    shad_pol;
   field_t        irq_line;
   field_t        hcnt, vcnt;

   logic [TW-1:0] h_total, v_total;
   logic [TW-1:0] hs_beg, hs_end, vs_beg, vs_end;
   logic          h_eol, v_eol, frame_end, commit, shadow_ok;
   logic          hs_act, vs_act;
   field_t        hcnt_nxt, vcnt_nxt;
   stage_t        fetch_stage;
   stage_t        pipe [LEAD+1];

   // Totals, wrap detection, sync decode and the fetch-stage view of the counters.
   always_comb begin
      // NOTE: every variable written here is assigned on every path (defaults first), so no latch is inferred.
      vcnt_nxt  = vcnt;
      h_total   = TW'(live_f[0]) + TW'(live_f[1]) + TW'(live_f[2]) + TW'(live_f[3]);
      v_total   = TW'(live_f[4]) + TW'(live_f[5]) + TW'(live_f[6]) + TW'(live_f[7]);
      // ">=" rather than "==" so a counter left beyond a shrunken total still wraps.
      h_eol     = (TW'(hcnt) + TW'(1)) >= h_total;
      v_eol     = (TW'(vcnt) + TW'(1)) >= v_total;
      frame_end = h_eol && v_eol;
      hcnt_nxt  = h_eol ? '0 : hcnt + field_t'(1);
      if (h_eol) vcnt_nxt = v_eol ? '0 : vcnt + field_t'(1);
      commit    = pix_ce && frame_end && cfg_pending;
      shadow_ok = (shad_f[0] != '0) && (shad_f[2] != '0) &&
                  (shad_f[4] != '0) && (shad_f[6] != '0);
      hs_beg    = TW'(live_f[0]) + TW'(live_f[1]);
      hs_end    = hs_beg + TW'(live_f[2]);
      vs_beg    = TW'(live_f[4]) + TW'(live_f[5]);
      vs_end    = vs_beg + TW'(live_f[6]);
      hs_act    = (TW'(hcnt) >= hs_beg) && (TW'(hcnt) < hs_end);
      vs_act    = (TW'(vcnt) >= vs_beg) && (TW'(vcnt) < vs_end);
      fetch_valid    = (hcnt < live_f[0]) && (vcnt < live_f[4]);
      fetch_stage.hs = hs_act ? live_pol[0] : ~live_pol[0];
      fetch_stage.vs = vs_act ? live_pol[1] : ~live_pol[1];
      fetch_stage.de = fetch_valid;
      // Position is zeroed outside the active area before it enters the pipe.
      fetch_stage.x  = fetch_valid ? hcnt : '0;
      fetch_stage.y  = fetch_valid ? vcnt : '0;
   end

   assign fetch_x = hcnt;
   assign fetch_y = vcnt;

   // Raster counters, shadow/live configuration, commit handshake and event pulses.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         hcnt        <= '0;
         vcnt        <= '0;
         for (int i = 0; i < 8; i++) begin
            live_f[i] <= field_default(3'(i));
            shad_f[i] <= field_default(3'(i));
         end
         live_pol    <= {V_POL, H_POL};
         shad_pol    <= {V_POL, H_POL};
         irq_line    <= '0;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
         frame_start <= 1'b0;
         line_irq    <= 1'b0;
      end else begin
         frame_start <= pix_ce && frame_end;
         line_irq    <= pix_ce && h_eol && (vcnt_nxt == irq_line) && (TW'(irq_line) < v_total);
         if (pix_ce) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
         end
         if (commit && shadow_ok) begin
            live_f   <= shad_f;
            live_pol <= shad_pol;
         end
         // A request in the commit cycle re-arms for the following frame.
         if (cfg_apply)   cfg_pending <= 1'b1;
         else if (commit) cfg_pending <= 1'b0;
         if (commit && !shadow_ok) cfg_err <= 1'b1;
         else if (cfg_apply)       cfg_err <= 1'b0;
         // Writes land after the commit has read the shadow, so they wait for the next apply.
         if (cfg_wr) begin
            if (cfg_sel < 4'd8)       shad_f[cfg_sel[2:0]] <= cfg_data;
            else if (cfg_sel == 4'd8) shad_pol             <= cfg_data[1:0];
            else if (cfg_sel == 4'd9) irq_line             <= cfg_data;
         end
      end
   end

   // Display-stage delay line: LEAD stages plus the output register.
   always_ff @(posedge clk) begin
      // NOTE: this is a handful of flops, not a RAM, so it is reset to known idle entries.
      if (rst) begin
         for (int i = 0; i <= LEAD; i++) pipe[i] <= IDLE;
      end else if (pix_ce) begin
         pipe[0] <= fetch_stage;
         for (int i = 1; i <= LEAD; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign h_sync_o = pipe[LEAD].hs;
   assign v_sync_o = pipe[LEAD].vs;
   assign de_o     = pipe[LEAD].de;
   assign posx_o   = pipe[LEAD].x;
   assign posy_o   = pipe[LEAD].y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scenario tasks plus a tick-level reference model of the raster.
// The model tracks screen position with plain integer arithmetic and a queue for the display delay.
module tb_vga_timing_gen;

   localparam int CW   = 11;
   localparam int LEAD = 2;
   // Small raster so whole frames fit in a short run.
   localparam int P_HA = 20, P_HF = 4, P_HS = 6, P_HB = 5;
   localparam int P_VA = 12, P_VF = 2, P_VS = 2, P_VB = 3;
   localparam int FRAME = (P_HA + P_HF + P_HS + P_HB) * (P_VA + P_VF + P_VS + P_VB);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pix_ce = 1'b0;
   logic          cfg_wr = 1'b0;
   logic [3:0]    cfg_sel = '0;
   logic [CW-1:0] cfg_data = '0;
   logic          cfg_apply = 1'b0;
   logic          cfg_pending, cfg_err, fetch_valid;
   logic [CW-1:0] fetch_x, fetch_y, posx_o, posy_o;
   logic          h_sync_o, v_sync_o, de_o, frame_start, line_irq;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CW(CW), .LEAD(LEAD),
      .H_ACT(P_HA), .H_FP(P_HF), .H_SW(P_HS), .H_BP(P_HB),
      .V_ACT(P_VA), .V_FP(P_VF), .V_SW(P_VS), .V_BP(P_VB),
      .H_POL(1'b0), .V_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce),
      .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_apply(cfg_apply),
      .cfg_pending(cfg_pending), .cfg_err(cfg_err),
      .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
      .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .de_o(de_o),
      .posx_o(posx_o), .posy_o(posy_o),
      .frame_start(frame_start), .line_irq(line_irq)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      bit hs;
      bit vs;
      bit de;
      int x;
      int y;
   } disp_t;

   int    m_live [8];
   int    m_shad [8];
   bit    m_hpol, m_vpol, m_shpol, m_svpol;
   int    m_h, m_v, m_irq;
   bit    m_pend, m_err, m_fs, m_li;
   disp_t m_exp;
   disp_t m_q [$];

   function automatic int field_default(int i);
      int d [8] = '{P_HA, P_HF, P_HS, P_HB, P_VA, P_VF, P_VS, P_VB};
      return d[i];
   endfunction

   function automatic disp_t idle_disp();
      disp_t d;
      d.hs = 1'b1; d.vs = 1'b1; d.de = 1'b0; d.x = 0; d.y = 0;
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_live[i] = field_default(i);
         m_shad[i] = field_default(i);
      end
      m_hpol = 0; m_vpol = 0; m_shpol = 0; m_svpol = 0;
      m_h = 0; m_v = 0; m_irq = 0;
      m_pend = 0; m_err = 0; m_fs = 0; m_li = 0;
      m_exp = idle_disp();
      m_q.delete();
      repeat (LEAD) m_q.push_back(idle_disp());
   endtask

   // Advance the reference by one clock using the inputs present at the edge.
   task automatic model_step();
      int    htot, vtot, hb, vb;
      bit    eol, eof, rej, ok;
      disp_t f;
      if (rst) begin
         model_reset();
         return;
      end
      htot = m_live[0] + m_live[1] + m_live[2] + m_live[3];
      vtot = m_live[4] + m_live[5] + m_live[6] + m_live[7];
      rej = 0; m_fs = 0; m_li = 0;
      if (pix_ce) begin
         hb   = m_live[0] + m_live[1];
         vb   = m_live[4] + m_live[5];
         f.hs = (m_h >= hb && m_h < hb + m_live[2]) ? m_hpol : !m_hpol;
         f.vs = (m_v >= vb && m_v < vb + m_live[6]) ? m_vpol : !m_vpol;
         f.de = (m_h < m_live[0]) && (m_v < m_live[4]);
         f.x  = f.de ? m_h : 0;
         f.y  = f.de ? m_v : 0;
         m_q.push_back(f);
         m_exp = m_q.pop_front();
         eol = (m_h + 1 >= htot);
         eof = eol && (m_v + 1 >= vtot);
         m_fs = eof;
         if (eof) begin
            if (m_pend) begin
               ok = (m_shad[0] != 0) && (m_shad[2] != 0) && (m_shad[4] != 0) && (m_shad[6] != 0);
               if (ok) begin
                  m_live = m_shad;
                  m_hpol = m_shpol;
                  m_vpol = m_svpol;
               end else rej = 1;
               m_pend = 0;
            end
            m_h = 0; m_v = 0;
         end else if (eol) begin
            m_h = 0; m_v++;
         end else m_h++;
         m_li = eol && (m_v == m_irq) && (m_irq < vtot);
      end
      if (rej) m_err = 1;
      else if (cfg_apply) m_err = 0;
      if (cfg_apply) m_pend = 1;
      if (cfg_wr) begin
         if (cfg_sel < 4'd8) m_shad[cfg_sel[2:0]] = int'(cfg_data);
         else if (cfg_sel == 4'd8) begin
            m_shpol = cfg_data[0];
            m_svpol = cfg_data[1];
         end else if (cfg_sel == 4'd9) m_irq = int'(cfg_data);
      end
   endtask

   // One clock: step the model at the edge, then compare every output 1 ns later.
   task automatic tick();
      bit exp_fv;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      exp_fv = (m_h < m_live[0]) && (m_v < m_live[4]);
      n_cmp++;
      if ({fetch_x, fetch_y, fetch_valid} !== {CW'(m_h), CW'(m_v), exp_fv}) begin
         n_fail++;
         $display("FAIL fetch @%0d: got x=%0d y=%0d v=%b expected x=%0d y=%0d v=%b",
                  cyc, fetch_x, fetch_y, fetch_valid, m_h, m_v, exp_fv);
      end
      n_cmp++;
      if ({h_sync_o, v_sync_o, de_o, posx_o, posy_o} !==
          {m_exp.hs, m_exp.vs, m_exp.de, CW'(m_exp.x), CW'(m_exp.y)}) begin
         n_fail++;
         $display("FAIL display @%0d: got hs=%b vs=%b de=%b x=%0d y=%0d expected hs=%b vs=%b de=%b x=%0d y=%0d",
                  cyc, h_sync_o, v_sync_o, de_o, posx_o, posy_o,
                  m_exp.hs, m_exp.vs, m_exp.de, m_exp.x, m_exp.y);
      end
      n_cmp++;
      if ({frame_start, line_irq} !== {m_fs, m_li}) begin
         n_fail++;
         $display("FAIL pulses @%0d: got fs=%b li=%b expected fs=%b li=%b",
                  cyc, frame_start, line_irq, m_fs, m_li);
      end
      n_cmp++;
      if ({cfg_pending, cfg_err} !== {m_pend, m_err}) begin
         n_fail++;
         $display("FAIL status @%0d: got pend=%b err=%b expected pend=%b err=%b",
                  cyc, cfg_pending, cfg_err, m_pend, m_err);
      end
   endtask

   task automatic do_write(input int sel, input int data);
      cfg_wr = 1'b1; cfg_sel = 4'(sel); cfg_data = CW'(data);
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic do_apply();
      cfg_apply = 1'b1;
      tick();
      cfg_apply = 1'b0;
   endtask

   // Runs until frame_start is seen; returns the number of clocks taken, or -1 on timeout.
   task automatic wait_frame(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (frame_start) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_frame: no frame_start within %0d clks", budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pix_ce = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({h_sync_o, v_sync_o, de_o, posx_o, posy_o} !== {1'b1, 1'b1, 1'b0, CW'(0), CW'(0)}) begin
         n_fail++;
         $display("FAIL reset_outputs: got hs=%b vs=%b de=%b x=%0d y=%0d expected 1 1 0 0 0",
                  h_sync_o, v_sync_o, de_o, posx_o, posy_o);
      end
      n_cmp++;
      if ({fetch_x, fetch_y, cfg_pending, cfg_err, frame_start, line_irq} !==
          {CW'(0), CW'(0), 4'b0000}) begin
         n_fail++;
         $display("FAIL reset_state: got x=%0d y=%0d pend=%b err=%b fs=%b li=%b expected all 0",
                  fetch_x, fetch_y, cfg_pending, cfg_err, frame_start, line_irq);
      end
      rst = 1'b0;
   endtask

   task automatic test_default_frame();
      int t_fs0, t_fs1, t_rise, t_de, xo, yo;
      bit pv, pd, exp_hs, exp_vs;
      int xq [$];
      int yq [$];
      t_fs0 = -1; t_fs1 = -1; t_rise = -1; t_de = -1;
      rst = 1'b1; pix_ce = 1'b1;
      tick();
      rst = 1'b0;
      xq.push_back(int'(fetch_x));
      yq.push_back(int'(fetch_y));
      pv = fetch_valid; pd = de_o;
      for (int i = 0; i < 1500; i++) begin
         tick();
         xq.push_back(int'(fetch_x));
         yq.push_back(int'(fetch_y));
         if (xq.size() == LEAD + 2) begin
            xo = xq.pop_front();
            yo = yq.pop_front();
            exp_hs = !(xo >= P_HA + P_HF && xo < P_HA + P_HF + P_HS);
            exp_vs = !(yo >= P_VA + P_VF && yo < P_VA + P_VF + P_VS);
            n_cmp++;
            if ({h_sync_o, v_sync_o} !== {exp_hs, exp_vs}) begin
               n_fail++;
               $display("FAIL sync_window @%0d: got hs=%b vs=%b expected hs=%b vs=%b (x=%0d y=%0d)",
                        cyc, h_sync_o, v_sync_o, exp_hs, exp_vs, xo, yo);
            end
         end
         if (frame_start) begin
            if (t_fs0 < 0) t_fs0 = cyc;
            else if (t_fs1 < 0) t_fs1 = cyc;
         end
         if (fetch_valid && !pv && t_rise < 0) t_rise = cyc;
         if (t_rise >= 0 && t_de < 0 && de_o && !pd) begin
            t_de = cyc;
            n_cmp++;
            if (posx_o !== CW'(0)) begin
               n_fail++;
               $display("FAIL first_de_posx: got %0d expected 0", posx_o);
            end
         end
         pv = fetch_valid; pd = de_o;
         if (t_fs1 >= 0 && t_de >= 0) break;
      end
      n_cmp++;
      if (t_fs1 - t_fs0 != FRAME || t_fs0 < 0) begin
         n_fail++;
         $display("FAIL frame_period: got %0d expected %0d", t_fs1 - t_fs0, FRAME);
      end
      n_cmp++;
      if (t_de - t_rise != LEAD + 1 || t_rise < 0 || t_de < 0) begin
         n_fail++;
         $display("FAIL de_latency: got %0d expected %0d", t_de - t_rise, LEAD + 1);
      end
   endtask

   task automatic test_commit();
      int n, prev_x, wraps;
      bit seen_fs;
      wait_frame(2000, n);
      repeat ($urandom_range(40, 400)) tick();
      do_write(0, 10);
      do_write(2, 3);
      do_apply();
      prev_x = int'(fetch_x);
      seen_fs = 0;
      for (int i = 0; i < 2000 && !seen_fs; i++) begin
         tick();
         if (frame_start) begin
            seen_fs = 1;
            n_cmp++;
            if (cfg_pending !== 1'b0 || prev_x != P_HA + P_HF + P_HS + P_HB - 1) begin
               n_fail++;
               $display("FAIL commit_wrap: got pend=%b last_x=%0d expected pend=0 last_x=%0d",
                        cfg_pending, prev_x, P_HA + P_HF + P_HS + P_HB - 1);
            end
         end else begin
            n_cmp++;
            if (cfg_pending !== 1'b1) begin
               n_fail++;
               $display("FAIL pending_hold: got %b expected 1", cfg_pending);
            end
            if (fetch_x == 0) begin
               n_cmp++;
               if (prev_x != P_HA + P_HF + P_HS + P_HB - 1) begin
                  n_fail++;
                  $display("FAIL old_line_len: got %0d expected %0d", prev_x + 1, P_HA + P_HF + P_HS + P_HB);
               end
            end
         end
         prev_x = int'(fetch_x);
      end
      if (!seen_fs) begin
         n_cmp++; n_fail++;
         $display("FAIL commit_timeout: no frame wrap seen");
      end
      wraps = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (fetch_x == 0) begin
            wraps++;
            n_cmp++;
            if (prev_x != 21) begin
               n_fail++;
               $display("FAIL new_line_len: got %0d expected 22", prev_x + 1);
            end
         end
         prev_x = int'(fetch_x);
      end
      n_cmp++;
      if (wraps < 10) begin
         n_fail++;
         $display("FAIL new_line_count: got %0d expected at least 10", wraps);
      end
   endtask

   task automatic test_reject();
      int n;
      do_write(4, 0);
      do_apply();
      wait_frame(2000, n);
      n_cmp++;
      if ({cfg_err, cfg_pending} !== 2'b10) begin
         n_fail++;
         $display("FAIL reject_flags: got err=%b pend=%b expected err=1 pend=0", cfg_err, cfg_pending);
      end
      wait_frame(2000, n);
      n_cmp++;
      if (n != 22 * 19) begin
         n_fail++;
         $display("FAIL reject_live_kept: got period %0d expected %0d", n, 22 * 19);
      end
      do_write(4, P_VA);
      do_apply();
      n_cmp++;
      if ({cfg_err, cfg_pending} !== 2'b01) begin
         n_fail++;
         $display("FAIL err_clear: got err=%b pend=%b expected err=0 pend=1", cfg_err, cfg_pending);
      end
      wait_frame(2000, n);
   endtask

   task automatic test_line_irq();
      int n, pulses;
      do_write(9, 5);
      wait_frame(2000, n);
      pulses = 0;
      for (int i = 0; i < 2 * 22 * 19; i++) begin
         tick();
         if (line_irq) begin
            pulses++;
            n_cmp++;
            if (fetch_x !== CW'(0) || fetch_y !== CW'(5)) begin
               n_fail++;
               $display("FAIL irq_position: got x=%0d y=%0d expected x=0 y=5", fetch_x, fetch_y);
            end
         end
      end
      n_cmp++;
      if (pulses != 2) begin
         n_fail++;
         $display("FAIL irq_count: got %0d expected 2", pulses);
      end
      do_write(9, 30);
      pulses = 0;
      for (int i = 0; i < 2 * 22 * 19; i++) begin
         tick();
         if (line_irq) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL irq_out_of_range: got %0d pulses expected 0", pulses);
      end
   endtask

   task automatic test_pix_ce_toggle();
      int t0, t1;
      t0 = -1; t1 = -1;
      rst = 1'b1; pix_ce = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         pix_ce = ~pix_ce;
         tick();
         if (frame_start) begin
            if (t0 < 0) t0 = cyc;
            else begin
               t1 = cyc;
               break;
            end
         end
      end
      pix_ce = 1'b1;
      n_cmp++;
      if (t0 < 0 || t1 < 0 || t1 - t0 != 2 * FRAME) begin
         n_fail++;
         $display("FAIL toggle_period: got %0d expected %0d", t1 - t0, 2 * FRAME);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      rst = 1'b1; pix_ce = 1'b1;
      tick();
      rst = 1'b0;
      do_write(1, 9);
      do_apply();
      repeat ($urandom_range(20, 300)) tick();
      n_cmp++;
      if (cfg_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pending: got %b expected 1", cfg_pending);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({fetch_x, fetch_y, cfg_pending, de_o, h_sync_o, v_sync_o, posx_o} !==
          {CW'(0), CW'(0), 1'b0, 1'b0, 1'b1, 1'b1, CW'(0)}) begin
         n_fail++;
         $display("FAIL mid_reset: got x=%0d y=%0d pend=%b de=%b hs=%b vs=%b px=%0d expected 0 0 0 0 1 1 0",
                  fetch_x, fetch_y, cfg_pending, de_o, h_sync_o, v_sync_o, posx_o);
      end
      wait_frame(2000, n);
      n_cmp++;
      if (n != FRAME) begin
         n_fail++;
         $display("FAIL mid_reset_defaults: got period %0d expected %0d", n, FRAME);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8000; i++) begin
         pix_ce    = ($urandom_range(0, 3) != 0);
         cfg_wr    = ($urandom_range(0, 19) == 0);
         cfg_sel   = 4'($urandom_range(0, 15));
         cfg_data  = CW'($urandom_range(0, 6));
         cfg_apply = ($urandom_range(0, 99) == 0);
         rst       = ($urandom_range(0, 2999) == 0);
         tick();
      end
      rst = 1'b0; cfg_wr = 1'b0; cfg_apply = 1'b0; pix_ce = 1'b1;
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_default_frame();
      test_commit();
      test_reject();
      test_line_irq();
      test_pix_ce_toggle();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
